svm_mc_infer_seq: RTL

Parametrised multi-class SVM inference sequencer. It is the successor to the single-class, fixed-32-lane inference controller, and sits between the config register block, the memory command/response port and the dot-product compute array. For every data point it computes one score per class: bias plus the chunked dot product of weights and data. It accumulates the partial sums internally, with no scratch stack. It writes the arg-max class index (one class: sign decision) to memory and pulses `batch_done` after the last point.

---
 rtl/svm_mc_infer_seq.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/svm_mc_infer_seq.sv
// Multi-class SVM inference sequencer: per point and class it loads the bias, walks
// weight/data chunks through the compute array, and writes the arg-max class.
module svm_mc_infer_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int LANES           = 32,
  parameter int NUM_CLASSES_MAX = 4,
  parameter int CNT_W           = 32,
  localparam int LW             = $clog2(LANES + 1),
  localparam int CW             = $clog2(NUM_CLASSES_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [CNT_W-1:0]      cfg_num_dim,
  input  logic [CNT_W-1:0]      cfg_num_dp,
  input  logic [CW-1:0]         cfg_num_classes,
  output logic                  busy,
  output logic                  batch_done,
  output logic                  cfg_err,
  output logic                  mem_err,
  output logic                  mem_cmd_vld,
  input  logic                  mem_cmd_rdy,
  output logic [1:0]            mem_cmd,
  output logic [CW-1:0]         mem_cmd_class,
  output logic [CNT_W-1:0]      mem_cmd_dp,
  output logic [CNT_W-1:0]      mem_cmd_off,
  output logic [LW-1:0]         mem_cmd_len,
  output logic [DATA_WIDTH-1:0] mem_cmd_data,
  input  logic                  mem_resp_vld,
  input  logic                  mem_resp_err,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  comp_start,
  output logic [LW-1:0]         comp_len,
  input  logic                  comp_done,
  input  logic [DATA_WIDTH-1:0] comp_psum
);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_WGT, S_DATA, S_COMP, S_CLS_END, S_WR_RES
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_num_dim, w_num_dim_next;
  logic [CNT_W-1:0]        r_num_dp, w_num_dp_next;
  logic [CW-1:0]           r_num_classes, w_num_classes_next;
  logic [CNT_W-1:0]        r_dp, w_dp_next;
  logic [CW-1:0]           r_class, w_class_next;
  logic [CW-1:0]           r_best, w_best_next;
  logic signed [DATA_WIDTH-1:0] r_best_score, w_best_score_next;
  logic signed [DATA_WIDTH-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0]        r_off, w_off_next;
  logic                    r_cmd_vld, w_cmd_vld_next;
  logic                    r_sent, w_sent_next;
  logic                    r_comp_started, w_comp_started_next;
  logic                    r_batch_done, w_batch_done_next;
  logic                    r_cfg_err, w_cfg_err_next;
  logic                    r_mem_err, w_mem_err_next;

  logic [CNT_W-1:0]        w_rem;
  logic [LW-1:0]           w_len;
  logic [CNT_W-1:0]        w_off_sum;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH-1:0]   w_sat;
  logic                    w_cmd_state;
  logic                    w_resp;

  // Chunk length: remaining elements, capped at the lane count.
  assign w_rem     = r_num_dim - r_off;
  assign w_len     = (w_rem > CNT_W'(LANES)) ? LW'(LANES) : w_rem[LW-1:0];
  assign w_off_sum = r_off + CNT_W'(w_len);

  // One extra bit exposes signed overflow of the accumulation.
  assign w_sum = {r_acc[DATA_WIDTH-1], r_acc} + {comp_psum[DATA_WIDTH-1], comp_psum};
  assign w_sat = (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1])
               ? (w_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX)
               : w_sum[DATA_WIDTH-1:0];

  assign w_cmd_state = (r_state == S_BIAS) || (r_state == S_WGT) ||
                       (r_state == S_DATA) || (r_state == S_WR_RES);
  // Responses count only once this visit's command has been handshaken.
  assign w_resp = w_cmd_state && r_sent && mem_resp_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_num_dim      <= '0;
      r_num_dp       <= '0;
      r_num_classes  <= '0;
      r_dp           <= '0;
      r_class        <= '0;
      r_best         <= '0;
      r_best_score   <= '0;
      r_acc          <= '0;
      r_off          <= '0;
      r_cmd_vld      <= 1'b0;
      r_sent         <= 1'b0;
      r_comp_started <= 1'b0;
      r_batch_done   <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_mem_err      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_num_dim      <= w_num_dim_next;
      r_num_dp       <= w_num_dp_next;
      r_num_classes  <= w_num_classes_next;
      r_dp           <= w_dp_next;
      r_class        <= w_class_next;
      r_best         <= w_best_next;
      r_best_score   <= w_best_score_next;
      r_acc          <= w_acc_next;
      r_off          <= w_off_next;
      r_cmd_vld      <= w_cmd_vld_next;
      r_sent         <= w_sent_next;
      r_comp_started <= w_comp_started_next;
      r_batch_done   <= w_batch_done_next;
      r_cfg_err      <= w_cfg_err_next;
      r_mem_err      <= w_mem_err_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_num_dim_next      = r_num_dim;
    w_num_dp_next       = r_num_dp;
    w_num_classes_next  = r_num_classes;
    w_dp_next           = r_dp;
    w_class_next        = r_class;
    w_best_next         = r_best;
    w_best_score_next   = r_best_score;
    w_acc_next          = r_acc;
    w_off_next          = r_off;
    w_cmd_vld_next      = r_cmd_vld;
    w_sent_next         = r_sent;
    w_comp_started_next = r_comp_started;
    w_batch_done_next   = 1'b0;
    w_cfg_err_next      = 1'b0;
    w_mem_err_next      = 1'b0;

    if (w_cmd_state) begin
      if (!r_cmd_vld && !r_sent) begin
        w_cmd_vld_next = 1'b1;
      end else if (r_cmd_vld && mem_cmd_rdy) begin
        w_cmd_vld_next = 1'b0;
        w_sent_next    = 1'b1;
      end
    end

    if (w_resp && mem_resp_err) begin
      w_state_next   = S_IDLE;
      w_mem_err_next = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            if ((cfg_num_classes == '0) || (cfg_num_classes > CW'(NUM_CLASSES_MAX))) begin
              w_cfg_err_next = 1'b1;
            end else if (cfg_num_dp == '0) begin
              w_batch_done_next = 1'b1;
            end else begin
              w_num_dim_next     = cfg_num_dim;
              w_num_dp_next      = cfg_num_dp;
              w_num_classes_next = cfg_num_classes;
              w_dp_next          = '0;
              w_class_next       = '0;
              w_best_next        = '0;
              w_state_next       = S_BIAS;
            end
          end
        end
        S_BIAS: begin
          if (w_resp) begin
            w_acc_next   = mem_resp_data;
            w_off_next   = '0;
            w_state_next = (r_num_dim != '0) ? S_WGT : S_CLS_END;
          end
        end
        S_WGT: begin
          if (w_resp) w_state_next = S_DATA;
        end
        S_DATA: begin
          if (w_resp) w_state_next = S_COMP;
        end
        S_COMP: begin
          w_comp_started_next = 1'b1;
          if (r_comp_started && comp_done) begin
            w_acc_next   = w_sat;
            w_off_next   = w_off_sum;
            w_state_next = (w_off_sum < r_num_dim) ? S_WGT : S_CLS_END;
          end
        end
        S_CLS_END: begin
          if (r_num_classes == CW'(1)) begin
            w_best_next = (r_acc > 0) ? CW'(1) : CW'(0);
          end else if ((r_class == '0) || (r_acc > r_best_score)) begin
            w_best_score_next = r_acc;
            w_best_next       = r_class;
          end
          if (r_class < (r_num_classes - CW'(1))) begin
            w_class_next = r_class + CW'(1);
            w_state_next = S_BIAS;
          end else begin
            w_state_next = S_WR_RES;
          end
        end
        S_WR_RES: begin
          if (w_resp) begin
            if (r_dp == (r_num_dp - CNT_W'(1))) begin
              w_batch_done_next = 1'b1;
              w_state_next      = S_IDLE;
            end else begin
              w_dp_next    = r_dp + CNT_W'(1);
              w_class_next = '0;
              w_state_next = S_BIAS;
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end

    // Every state entry starts a fresh command / compute phase.
    if (w_state_next != r_state) begin
      w_cmd_vld_next      = 1'b0;
      w_sent_next         = 1'b0;
      w_comp_started_next = 1'b0;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign batch_done  = r_batch_done;
  assign cfg_err     = r_cfg_err;
  assign mem_err     = r_mem_err;
  assign mem_cmd_vld = r_cmd_vld;
  assign comp_start  = (r_state == S_COMP) && !r_comp_started;
  assign comp_len    = comp_start ? w_len : '0;

  always_comb begin
    mem_cmd       = 2'd0;
    mem_cmd_class = '0;
    mem_cmd_dp    = '0;
    mem_cmd_off   = '0;
    mem_cmd_len   = '0;
    mem_cmd_data  = '0;
    if (r_cmd_vld) begin
      case (r_state)
        S_BIAS: begin
          mem_cmd       = 2'd0;
          mem_cmd_class = r_class;
          mem_cmd_dp    = r_dp;
        end
        S_WGT: begin
          mem_cmd       = 2'd1;
          mem_cmd_class = r_class;
          mem_cmd_off   = r_off;
          mem_cmd_len   = w_len;
        end
        S_DATA: begin
          mem_cmd     = 2'd2;
          mem_cmd_dp  = r_dp;
          mem_cmd_off = r_off;
          mem_cmd_len = w_len;
        end
        S_WR_RES: begin
          mem_cmd      = 2'd3;
          mem_cmd_dp   = r_dp;
          mem_cmd_data = DATA_WIDTH'(r_best);
        end
        default: ;
      endcase
    end
  end

endmodule
